// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   hz_state_t   : controller state (RUN, MEM_WAIT, HALTED)
//   REG_ZERO     : index of the hard-wired zero register
//   stage_ctrl_t : bundle of per-stage enables and flushes
//   CTRL_*       : canned control patterns used by the controller FSM
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2
  } hz_state_t;

  localparam int unsigned REG_ZERO = 0;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
  } stage_ctrl_t;

  // Field order: pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush
  localparam stage_ctrl_t CTRL_FREEZE = stage_ctrl_t'(7'b00000_00);
  localparam stage_ctrl_t CTRL_RUN    = stage_ctrl_t'(7'b11111_00);
  localparam stage_ctrl_t CTRL_FLUSH  = stage_ctrl_t'(7'b11111_11);
  // Hold PC and IF/ID, let the rest drain, and turn ID/EX into a bubble.
  localparam stage_ctrl_t CTRL_BUBBLE = stage_ctrl_t'(7'b00111_01);

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk   : clock
//   reset : synchronous, active-low reset (count -> 0)
//   inc   : increment request, ignored once count is all-ones
//   clr   : synchronous clear, wins over inc
//   count : current value
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller for a five-stage IF/ID/EX/MEM/WB pipeline.
// Generates stage enables/flushes to resolve load-use hazards, multi-cycle
// data-memory accesses, taken branches and external halts, and keeps
// saturating stall/flush performance counters.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal flow; hazards resolved combinationally (Mealy)
// MEM_WAIT | whole pipeline frozen for the rest of a memory access
// HALTED   | whole pipeline frozen until halt_req drops
//
// Ports:
//   clk, reset                 : clock, synchronous active-low reset
//   id_rs1/id_rs2, id_uses_rs* : source operands of the ID instruction
//   ex_rd, ex_mem_read,
//   ex_reg_write               : destination info of the EX instruction
//   mem_access_start           : MEM begins a load/store this cycle
//   branch_taken_ex            : taken branch/jump resolved in EX
//   halt_req                   : external halt request
//   perf_clear                 : clears both performance counters
//   pc_enable .. mem_wb_enable : register enables
//   if_id_flush, id_ex_flush   : register clears
//   halted                     : controller is in HALTED
//   stall_cycles, flush_count  : saturating performance counters
module pipeline_hazard_controller
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W       = 4,
  parameter int MEM_STALL_CYCLES = 2,
  parameter int CNT_W            = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_reg_write,
  input  logic                  mem_access_start,
  input  logic                  branch_taken_ex,
  input  logic                  halt_req,
  input  logic                  perf_clear,
  output logic                  pc_enable,
  output logic                  if_id_enable,
  output logic                  id_ex_enable,
  output logic                  ex_mem_enable,
  output logic                  mem_wb_enable,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  halted,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);

  localparam bit       MEM_FREEZE_EN = (MEM_STALL_CYCLES > 0);
  localparam bit       MEM_MULTI     = (MEM_STALL_CYCLES > 1);
  // The access-start cycle is itself frozen, so MEM_WAIT covers N-1 cycles.
  localparam logic [3:0] WAIT_INIT   =
    (MEM_STALL_CYCLES > 0) ? 4'(MEM_STALL_CYCLES - 1) : 4'd0;

  hz_state_t   state, state_nxt;
  logic [3:0]  wait_cnt, wait_nxt;
  stage_ctrl_t ctrl;
  logic        halted_c;
  logic        stall_inc;
  logic        flush_inc;
  logic        luh;

  assign luh = ex_mem_read && ex_reg_write &&
               (ex_rd != REG_ADDR_W'(REG_ZERO)) &&
               ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= RUN;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    ctrl      = CTRL_FREEZE;
    halted_c  = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    unique case (state)
      RUN: begin
        if (halt_req) begin
          state_nxt = HALTED;
        end else if (mem_access_start && MEM_FREEZE_EN) begin
          stall_inc = 1'b1;
          wait_nxt  = WAIT_INIT;
          state_nxt = MEM_MULTI ? MEM_WAIT : RUN;
        end else if (branch_taken_ex) begin
          // Any load-use hazard is moot: the dependent instruction is flushed.
          ctrl      = CTRL_FLUSH;
          flush_inc = 1'b1;
        end else if (luh) begin
          ctrl      = CTRL_BUBBLE;
          stall_inc = 1'b1;
        end else begin
          ctrl = CTRL_RUN;
        end
      end
      MEM_WAIT: begin
        // halt_req is deliberately not sampled here; RUN picks it up later.
        stall_inc = 1'b1;
        if (wait_cnt <= 4'd1) begin
          state_nxt = RUN;
          wait_nxt  = 4'd0;
        end else begin
          wait_nxt = wait_cnt - 4'd1;
        end
      end
      HALTED: begin
        halted_c = 1'b1;
        if (!halt_req) state_nxt = RUN;
      end
      default: begin
        state_nxt = RUN;
        wait_nxt  = 4'd0;
      end
    endcase
  end

  assign pc_enable     = reset & ctrl.pc_en;
  assign if_id_enable  = reset & ctrl.if_id_en;
  assign id_ex_enable  = reset & ctrl.id_ex_en;
  assign ex_mem_enable = reset & ctrl.ex_mem_en;
  assign mem_wb_enable = reset & ctrl.mem_wb_en;
  assign if_id_flush   = reset & ctrl.if_id_flush;
  assign id_ex_flush   = reset & ctrl.id_ex_flush;
  assign halted        = reset & halted_c;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .clr   (perf_clear),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .clr   (perf_clear),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
module tb_pipeline_hazard_controller;

  localparam int RW   = 4;
  localparam int NMEM = 3;
  localparam int CW   = 8;
  localparam int SAT  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [RW-1:0] id_rs1, id_rs2, ex_rd;
  logic          id_uses_rs1, id_uses_rs2, ex_mem_read, ex_reg_write;
  logic          mem_access_start, branch_taken_ex, halt_req, perf_clear;
  logic          pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable;
  logic          if_id_flush, id_ex_flush, halted;
  logic [CW-1:0] stall_cycles, flush_count;

  int checks   = 0;
  int failures = 0;

  // Reference model: remaining frozen cycles, halt flag, counter values.
  int m_freeze = 0;
  bit m_halted = 1'b0;
  int m_stall  = 0;
  int m_flush  = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(
    .REG_ADDR_W(RW), .MEM_STALL_CYCLES(NMEM), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .mem_access_start(mem_access_start), .branch_taken_ex(branch_taken_ex),
    .halt_req(halt_req), .perf_clear(perf_clear),
    .pc_enable(pc_enable), .if_id_enable(if_id_enable), .id_ex_enable(id_ex_enable),
    .ex_mem_enable(ex_mem_enable), .mem_wb_enable(mem_wb_enable),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .halted(halted),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    reset = 1'b1;
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_mem_read = 1'b0; ex_reg_write = 1'b0;
    mem_access_start = 1'b0; branch_taken_ex = 1'b0;
    halt_req = 1'b0; perf_clear = 1'b0;
  endtask

  // One clock: predict outputs from the rules, compare mid-cycle, advance model.
  task automatic step(input string tag);
    logic [7:0] e;  // {pc, if_id, id_ex, ex_mem, mem_wb, if_flush, id_flush, halted}
    bit hz, s_inc, f_inc;
    hz = ex_mem_read && ex_reg_write && (ex_rd != '0) &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    e = 8'h00; s_inc = 1'b0; f_inc = 1'b0;
    if (!reset) begin
      e = 8'h00;
    end else if (m_halted) begin
      e = 8'b0000_0001;
    end else if (m_freeze > 0) begin
      s_inc = 1'b1;
    end else if (halt_req) begin
      e = 8'h00;
    end else if (mem_access_start) begin
      s_inc = 1'b1;
    end else if (branch_taken_ex) begin
      e = 8'b11111_11_0; f_inc = 1'b1;
    end else if (hz) begin
      e = 8'b00111_01_0; s_inc = 1'b1;
    end else begin
      e = 8'b11111_00_0;
    end

    @(negedge clk);
    check({tag, ".ctrl"}, 32'({pc_enable, if_id_enable, id_ex_enable, ex_mem_enable,
                               mem_wb_enable, if_id_flush, id_ex_flush, halted}), 32'(e));
    check({tag, ".stall"}, 32'(stall_cycles), 32'(m_stall));
    check({tag, ".flush"}, 32'(flush_count), 32'(m_flush));

    if (!reset) begin
      m_freeze = 0; m_halted = 1'b0; m_stall = 0; m_flush = 0;
    end else begin
      if (m_halted) begin
        if (!halt_req) m_halted = 1'b0;
      end else if (m_freeze > 0) begin
        m_freeze--;
      end else if (halt_req) begin
        m_halted = 1'b1;
      end else if (mem_access_start) begin
        m_freeze = NMEM - 1;
      end
      if (perf_clear) begin
        m_stall = 0; m_flush = 0;
      end else begin
        if (s_inc && m_stall < SAT) m_stall++;
        if (f_inc && m_flush < SAT) m_flush++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    @(posedge clk); #1;
    step("reset0");
    step("reset1");
    reset = 1'b1;
    step("idle");

    // Load-use on rs2
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 4'd5;
    id_uses_rs2 = 1'b1; id_rs2 = 4'd5;
    step("luh");
    idle();
    step("luh_after");

    // Destination x0 never creates a hazard
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 4'd0;
    id_uses_rs1 = 1'b1; id_rs1 = 4'd0;
    step("rd_zero");

    // Branch together with a load-use hazard
    ex_rd = 4'd7; id_rs1 = 4'd7; branch_taken_ex = 1'b1;
    step("br_luh");
    idle();
    step("br_after");

    // Memory freeze with halt raised in the second frozen cycle
    mem_access_start = 1'b1;
    step("mem0");
    mem_access_start = 1'b0; halt_req = 1'b1;
    step("mem1");
    step("mem2");
    step("mem_halt_run");
    step("mem_halted");
    halt_req = 1'b0;
    step("mem_release");
    step("mem_resume");

    // Halt for four cycles from RUN
    halt_req = 1'b1;
    for (int i = 0; i < 4; i++) step("halt");
    halt_req = 1'b0;
    step("halt_release");
    step("halt_resume");

    // Stall counter saturation, then clear
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 4'd3;
    id_uses_rs1 = 1'b1; id_rs1 = 4'd3;
    for (int i = 0; i < SAT + 6; i++) step("sat");
    idle();
    step("sat_hold");
    perf_clear = 1'b1;
    step("clear");
    perf_clear = 1'b0;
    step("clear_after");

    // Reset in the middle of a memory freeze
    mem_access_start = 1'b1;
    step("rmem0");
    mem_access_start = 1'b0;
    step("rmem1");
    reset = 1'b0;
    step("rmem_reset");
    reset = 1'b1;
    step("rmem_run");
    step("rmem_run2");

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset            = ($urandom_range(0, 99) >= 2);
      id_rs1           = RW'($urandom_range(0, 3));
      id_rs2           = RW'($urandom_range(0, 3));
      ex_rd            = RW'($urandom_range(0, 3));
      id_uses_rs1      = $urandom_range(0, 1) != 0;
      id_uses_rs2      = $urandom_range(0, 1) != 0;
      ex_mem_read      = $urandom_range(0, 1) != 0;
      ex_reg_write     = $urandom_range(0, 3) != 0;
      mem_access_start = $urandom_range(0, 9) == 0;
      branch_taken_ex  = $urandom_range(0, 6) == 0;
      halt_req         = (m_halted ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 19) == 0));
      perf_clear       = $urandom_range(0, 49) == 0;
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Produces per-stage enable and flush controls for the five-stage pipeline (IF/ID/EX/MEM/WB) and the PC register.
- Detects three conditions and resolves them by stalling, freezing or flushing stages:
  - load-use data hazards;
  - multi-cycle data-memory accesses;
  - taken branches resolved in EX.
- Also handles an external halt request and keeps saturating stall/flush performance counters.
- Sits alongside the datapath and drives the enable/clear inputs of every inter-stage pipeline register.

Parameters:
- REG_ADDR_W, 4, register-index width.
- MEM_STALL_CYCLES, 2, total cycles the whole pipeline is frozen per data-memory access. Legal range 0..15; 0 means no freeze.
- CNT_W, 16, performance-counter width.

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous, active-low.
- id_rs1, in, REG_ADDR_W, source register 1 of the instruction in ID.
- id_rs2, in, REG_ADDR_W, source register 2 of the instruction in ID.
- id_uses_rs1, in, 1, ID instruction reads rs1.
- id_uses_rs2, in, 1, ID instruction reads rs2.
- ex_rd, in, REG_ADDR_W, destination register of the instruction in EX.
- ex_mem_read, in, 1, EX instruction is a load.
- ex_reg_write, in, 1, EX instruction writes the register file.
- mem_access_start, in, 1, MEM stage begins a load or store this cycle.
- branch_taken_ex, in, 1, branch/jump in EX is taken.
- halt_req, in, 1, external halt request.
- perf_clear, in, 1, clears both performance counters.
- pc_enable, out, 1, PC update enable.
- if_id_enable, out, 1, IF/ID register enable.
- id_ex_enable, out, 1, ID/EX register enable.
- ex_mem_enable, out, 1, EX/MEM register enable.
- mem_wb_enable, out, 1, MEM/WB register enable.
- if_id_flush, out, 1, IF/ID register clear.
- id_ex_flush, out, 1, ID/EX register clear.
- halted, out, 1, controller is in HALTED.
- stall_cycles, out, CNT_W, saturating count of stall/freeze cycles.
- flush_count, out, CNT_W, saturating count of branch flushes.

Behaviour:
- Reset (reset==0 at posedge):
  - state<=RUN, wait_cnt<=0, stall_cycles<=0, flush_count<=0.
  - While reset is low, all enables, flushes and halted are forced to 0.
- States: RUN, MEM_WAIT, HALTED.
- Control outputs are Mealy in RUN and Moore in MEM_WAIT and HALTED.
- Load-use hazard (luh) = ex_mem_read & ex_reg_write & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- RUN, evaluated in priority order; the first matching case applies:
  1. halt_req: all enables 0, no flush. Next state HALTED.
  2. mem_access_start & MEM_STALL_CYCLES>0: all enables 0. wait_cnt<=MEM_STALL_CYCLES-1. Next state MEM_WAIT if MEM_STALL_CYCLES>1, else RUN.
  3. branch_taken_ex: all enables 1, if_id_flush=1, id_ex_flush=1. flush_count++ (saturating). A simultaneous luh is ignored, because the hazarding instruction is being flushed.
  4. luh: pc_enable=0, if_id_enable=0, id_ex_flush=1; all other enables 1. This inserts exactly one bubble; no state change.
  5. Otherwise: all enables 1, flushes 0.
- MEM_WAIT:
  - All enables 0, flushes 0.
  - If wait_cnt==1, next state RUN; else wait_cnt--.
  - mem_access_start, branch_taken_ex and luh are ignored in this state.
  - halt_req is not acted on here; it is evaluated again in RUN, so a halt is deferred until the access completes.
- HALTED:
  - All enables 0, halted=1.
  - Next state RUN on the first cycle halt_req==0.
  - Normal RUN behaviour resumes in the cycle after that.
- Exact freeze length:
  - Every accepted access gives exactly MEM_STALL_CYCLES consecutive cycles with all enables 0, counting the mem_access_start cycle.
  - Back-to-back accesses re-trigger only from RUN.
- stall_cycles:
  - Increments each cycle pc_enable==0 with state!=HALTED and halt not being entered (cases 2 and 4 and MEM_WAIT).
  - Saturates at all-ones.
- Counter clear:
  - perf_clear has priority over increment; both counters become 0 on the next edge.
  - Reset also clears them.
- Reset mid-operation: MEM_WAIT or HALTED is abandoned immediately; next cycle is RUN with wait_cnt=0.

Decomposition:
- Shared package pipeline_pkg holds:
  - the state enum hz_state_t {RUN, MEM_WAIT, HALTED};
  - the constant REG_ZERO;
  - a packed struct stage_ctrl_t {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush}.
- One sub-module, sat_counter (width parameter, inc, clr, synchronous active-low reset), instantiated twice for the performance counters.

Test Plan:
- Load-use: ex_mem_read=1, ex_reg_write=1, ex_rd=5, id_uses_rs2=1, id_rs2=5 → for one cycle pc_enable=0, if_id_enable=0, id_ex_flush=1; stall_cycles 0→1.
- ex_rd=0 with matching id_rs1=0, load in EX → no stall; all enables 1.
- Branch plus hazard: branch_taken_ex=1 while luh is true → if_id_flush=id_ex_flush=1, pc_enable=1; flush_count=1; stall_cycles unchanged.
- Memory freeze: MEM_STALL_CYCLES=3, pulse mem_access_start → exactly 3 cycles with all enables 0, then RUN; halt_req raised in the 2nd frozen cycle → HALTED entered only after the 3rd.
- Halt: halt_req high for 4 cycles from RUN → halted=1 for 4 cycles; enables 1 the cycle after release; stall_cycles not incremented.
- Counters/reset: force 0xFFFF stall cycles → stall_cycles holds 0xFFFF; perf_clear → 0; reset low during MEM_WAIT → all enables 0, then RUN with enables 1.
